list_packer: RTL and testbench

//  Write-back counterpart of the list-reading cache: collects DW-bit list elements produced by a HoP

---
 rtl/list_pkg.sv | 23 ++
 rtl/list_beat_fifo.sv | 54 +++++
 rtl/list_packer.sv | 99 +++++++++
 tb/tb_list_packer.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/list_pkg.sv
// Shared types for the list-reading cache and the list packer.
// Elements are DW bits wide and FS of them form one DBW-bit stream beat.
// The word-count field exists only when LIST_PACKER_TKEEP_EN is defined.
package list_pkg;

  localparam int DW     = 32;
  localparam int DBW    = 256;
  localparam int FS     = DBW / DW;
  localparam int LANE_W = $clog2(FS);

  typedef logic [LANE_W-1:0]       lane_idx_t;
  typedef logic [LANE_W:0]         count_t;     // holds 1..FS
  typedef logic [FS-1:0][DW-1:0]   beat_t;

  typedef struct packed {
    beat_t  data;
    logic   last;
`ifdef LIST_PACKER_TKEEP_EN
    count_t n;
`endif
  } fifo_entry_t;

endpackage

// File: rtl/list_beat_fifo.sv
// Synchronous beat FIFO of fifo_entry_t with async active-low reset.
// DEPTH must be a power of two, so the pointers wrap without compare logic.
// The storage is reset to zero, which makes the head (and TDATA) read 0 after reset.
module list_beat_fifo
  import list_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic                     push,
  input  fifo_entry_t              din,
  input  logic                     pop,
  output fifo_entry_t              dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_N = DEPTH[AW:0];

  fifo_entry_t   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          push_ok, pop_ok;

  assign full    = (count == FULL_N);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage, pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/list_packer.sv
// Packs DW-bit list elements into DBW-bit AXI4-Stream beats, marking list ends with TLAST.
// Optional feature: define LIST_PACKER_TKEEP_EN to add the TKEEP port (lane-granular byte enables).
// O_READY depends only on registered state, so there is no path from TREADY or I_VALID to it.
module list_packer
  import list_pkg::*;
#(
  parameter int BS = 2
) (
  input  logic             ACLK,
  input  logic             ARESETn,
  input  logic [DW-1:0]    IN,
  input  logic             I_VALID,
  input  logic             I_LAST,
  output logic             O_READY,
  output logic [DBW-1:0]   TDATA,
  output logic             TVALID,
  input  logic             TREADY,
  output logic             TLAST,
`ifdef LIST_PACKER_TKEEP_EN
  output logic [DBW/8-1:0] TKEEP,
`endif
  output logic [3:0]       TDEST,
  output logic [7:0]       TID,
  output logic [DBW-1:0]   TUSER
);

  logic                 run_q;     // low during reset, high from the first edge after release
  lane_idx_t            idx_q;
  beat_t                asm_q;
  beat_t                beat_nxt;
  fifo_entry_t          push_e, head;
  logic                 accept, close, pop;
  logic                 full, empty;
  logic [$clog2(BS):0]  fcount;

  assign O_READY = run_q & ~full;
  assign accept  = I_VALID & O_READY;
  assign close   = accept & ((idx_q == lane_idx_t'(FS-1)) | I_LAST);

  // Assembly register with the incoming word dropped into its lane.
  always_comb begin
    beat_nxt        = asm_q;
    beat_nxt[idx_q] = IN;
    push_e          = '0;
    push_e.data     = beat_nxt;
    push_e.last     = I_LAST;
`ifdef LIST_PACKER_TKEEP_EN
    push_e.n        = count_t'(idx_q) + count_t'(1);
`endif
  end

  // Packing counter and assembly register; a closed beat leaves a clean, zeroed register.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      run_q <= 1'b0;
      idx_q <= '0;
      asm_q <= '0;
    end else begin
      run_q <= 1'b1;
      if (accept) begin
        if (close) begin
          idx_q <= '0;
          asm_q <= '0;
        end else begin
          idx_q <= idx_q + 1'b1;
          asm_q <= beat_nxt;
        end
      end
    end
  end

  list_beat_fifo #(.DEPTH(BS)) u_fifo (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .push    (close),
    .din     (push_e),
    .pop     (pop),
    .dout    (head),
    .full    (full),
    .empty   (empty),
    .count   (fcount)
  );

  assign TVALID = (fcount != '0);
  assign pop    = ~empty & TREADY;
  assign TDATA  = head.data;
  assign TLAST  = head.last;
  assign TDEST  = '0;
  assign TID    = '0;
  assign TUSER  = '0;

`ifdef LIST_PACKER_TKEEP_EN
  // Every byte of a lane below the beat's word count is kept.
  for (genvar k = 0; k < FS; k++) begin : g_keep
    assign TKEEP[k*(DW/8) +: DW/8] = {(DW/8){count_t'(k) < head.n}};
  end
`endif

endmodule

// File: tb/tb_list_packer.sv
// Directed bench for list_packer (DW=32, DBW=256, FS=8, BS=2).
// Inputs change 1 time unit after the rising edge, and outputs are sampled on the falling edge.
module tb_list_packer;

  logic         ACLK = 1'b0;
  logic         ARESETn;
  logic [31:0]  IN;
  logic         I_VALID, I_LAST, O_READY;
  logic [255:0] TDATA;
  logic         TVALID, TREADY, TLAST;
`ifdef LIST_PACKER_TKEEP_EN
  logic [31:0]  TKEEP;
`endif
  logic [3:0]   TDEST;
  logic [7:0]   TID;
  logic [255:0] TUSER;

  int vectors = 0;
  int fails   = 0;

  logic tready_val;
  logic rand_mode;

  typedef struct {
    logic [255:0] d;
    logic         l;
    logic [31:0]  k;
  } beat_s;

  beat_s        cap[$];
  logic         prev_stall = 1'b0;
  logic [255:0] prev_d;
  logic         prev_l;

  always #5 ACLK = ~ACLK;

  list_packer dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .IN      (IN),
    .I_VALID (I_VALID),
    .I_LAST  (I_LAST),
    .O_READY (O_READY),
    .TDATA   (TDATA),
    .TVALID  (TVALID),
    .TREADY  (TREADY),
    .TLAST   (TLAST),
`ifdef LIST_PACKER_TKEEP_EN
    .TKEEP   (TKEEP),
`endif
    .TDEST   (TDEST),
    .TID     (TID),
    .TUSER   (TUSER)
  );

  // TREADY source: a fixed level, or a coin flip every cycle
  always begin
    TREADY = 1'b0;
    forever begin
      @(posedge ACLK);
      #2;
      TREADY = rand_mode ? 1'($urandom_range(0, 1)) : tready_val;
    end
  end

  // Monitor: capture handshaken beats, and require the head to hold while stalled
  always @(negedge ACLK) begin
    beat_s b;
    if (ARESETn === 1'b1 && prev_stall) begin
      vectors++;
      if (TVALID !== 1'b1 || TDATA !== prev_d || TLAST !== prev_l) begin
        fails++;
        $display("FAIL stall_hold: tvalid=%b tlast=%b tdata=%h required tvalid=1 tlast=%b tdata=%h",
                 TVALID, TLAST, TDATA, prev_l, prev_d);
      end
    end
    if (ARESETn === 1'b1 && TVALID === 1'b1 && TREADY === 1'b1) begin
      b.d = TDATA;
      b.l = TLAST;
`ifdef LIST_PACKER_TKEEP_EN
      b.k = TKEEP;
`else
      b.k = '1;
`endif
      cap.push_back(b);
    end
    prev_stall = (ARESETn === 1'b1) && (TVALID === 1'b1) && (TREADY !== 1'b1);
    prev_d     = TDATA;
    prev_l     = TLAST;
  end

  // Present one word and hold it until accepted; starts and ends 1 after a rising edge
  task automatic send(input logic [31:0] d, input logic l);
    int t = 0;
    IN = d; I_VALID = 1'b1; I_LAST = l;
    @(negedge ACLK);
    while (O_READY !== 1'b1 && t < 300) begin
      @(negedge ACLK);
      t++;
    end
    if (O_READY !== 1'b1) begin
      vectors++; fails++;
      $display("FAIL send_timeout: word %h not accepted, o_ready=%b required 1", d, O_READY);
    end
    @(posedge ACLK); #1;
    I_VALID = 1'b0; I_LAST = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget);
    int t = 0;
    while (cap.size() < n && t < budget) begin
      @(negedge ACLK);
      t++;
    end
    if (cap.size() < n) begin
      vectors++; fails++;
      $display("FAIL beat_timeout: got %0d beats required %0d", cap.size(), n);
    end
    repeat (3) @(negedge ACLK);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge ACLK);
    vectors++;
    if ({O_READY, TVALID, TLAST} !== 3'b000) begin
      fails++; $display("FAIL reset_ctrl: o_ready/tvalid/tlast=%b required 000", {O_READY, TVALID, TLAST});
    end
    vectors++;
    if (TDATA !== 256'h0) begin
      fails++; $display("FAIL reset_tdata: tdata=%h required 0", TDATA);
    end
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    @(negedge ACLK);
    vectors++;
    if (O_READY !== 1'b0) begin
      fails++; $display("FAIL release_ready: o_ready=%b required 0 before first edge", O_READY);
    end
    @(negedge ACLK);
    vectors++;
    if (O_READY !== 1'b1) begin
      fails++; $display("FAIL release_ready2: o_ready=%b required 1", O_READY);
    end
    @(posedge ACLK); #1;
  endtask

  task automatic test_full_beat;
    cap.delete();
    tready_val = 1'b1;
    @(posedge ACLK); #1;
    for (int i = 1; i <= 8; i++) send(32'(i), i == 8);
    @(negedge ACLK);
    vectors++;
    if (TVALID !== 1'b1) begin
      fails++; $display("FAIL latency: tvalid=%b required 1 in cycle after close", TVALID);
    end
    wait_beats(1, 50);
    vectors++;
    if (cap.size() != 1) begin
      fails++; $display("FAIL full_count: beats=%0d required 1", cap.size());
    end
    if (cap.size() > 0) begin
      vectors++;
      if (cap[0].d !== 256'h00000008_00000007_00000006_00000005_00000004_00000003_00000002_00000001) begin
        fails++; $display("FAIL full_tdata: tdata=%h", cap[0].d);
      end
      vectors++;
      if (cap[0].l !== 1'b1) begin
        fails++; $display("FAIL full_tlast: tlast=%b required 1", cap[0].l);
      end
`ifdef LIST_PACKER_TKEEP_EN
      vectors++;
      if (cap[0].k !== 32'hFFFFFFFF) begin
        fails++; $display("FAIL full_tkeep: tkeep=%h required ffffffff", cap[0].k);
      end
`endif
    end
    @(posedge ACLK); #1;
  endtask

  task automatic test_partial;
    cap.delete();
    send(32'hA0A0A0A0, 1'b0);
    send(32'hB1B1B1B1, 1'b0);
    send(32'hC2C2C2C2, 1'b1);
    wait_beats(1, 50);
    vectors++;
    if (cap.size() != 1) begin
      fails++; $display("FAIL partial_count: beats=%0d required 1", cap.size());
    end
    if (cap.size() > 0) begin
      vectors++;
      if (cap[0].d !== 256'h00000000_00000000_00000000_00000000_00000000_C2C2C2C2_B1B1B1B1_A0A0A0A0) begin
        fails++; $display("FAIL partial_tdata: tdata=%h", cap[0].d);
      end
      vectors++;
      if (cap[0].l !== 1'b1) begin
        fails++; $display("FAIL partial_tlast: tlast=%b required 1", cap[0].l);
      end
`ifdef LIST_PACKER_TKEEP_EN
      vectors++;
      if (cap[0].k !== 32'h00000FFF) begin
        fails++; $display("FAIL partial_tkeep: tkeep=%h required 00000fff", cap[0].k);
      end
`endif
    end
    @(posedge ACLK); #1;
  endtask

  task automatic test_backpressure;
    logic [255:0] exp_d [3];
    exp_d[0] = 256'h00000107_00000106_00000105_00000104_00000103_00000102_00000101_00000100;
    exp_d[1] = 256'h0000010F_0000010E_0000010D_0000010C_0000010B_0000010A_00000109_00000108;
    exp_d[2] = 256'h00000117_00000116_00000115_00000114_00000113_00000112_00000111_00000110;
    cap.delete();
    tready_val = 1'b0;
    @(posedge ACLK); #1;
    for (int i = 0; i < 16; i++) send(32'h100 + 32'(i), 1'b0);
    @(negedge ACLK);
    vectors++;
    if (O_READY !== 1'b0 || TVALID !== 1'b1) begin
      fails++; $display("FAIL bp_full: o_ready=%b tvalid=%b required 0 1", O_READY, TVALID);
    end
    vectors++;
    if (TDATA !== exp_d[0]) begin
      fails++; $display("FAIL bp_head: tdata=%h required %h", TDATA, exp_d[0]);
    end
    @(posedge ACLK); #1;
    tready_val = 1'b1;
    for (int i = 16; i < 24; i++) send(32'h100 + 32'(i), i == 23);
    wait_beats(3, 100);
    vectors++;
    if (cap.size() != 3) begin
      fails++; $display("FAIL bp_count: beats=%0d required 3", cap.size());
    end
    for (int b = 0; b < 3 && b < cap.size(); b++) begin
      vectors++;
      if (cap[b].d !== exp_d[b] || cap[b].l !== (b == 2)) begin
        fails++;
        $display("FAIL bp_beat%0d: tdata=%h tlast=%b required %h %b", b, cap[b].d, cap[b].l, exp_d[b], b == 2);
      end
    end
    @(posedge ACLK); #1;
  endtask

  task automatic test_random;
    beat_s        expq[$];
    beat_s        e;
    logic [255:0] m = '0;
    int           mi = 0;
    int           t = 0;
    logic [31:0]  w;
    logic         l;
    cap.delete();
    rand_mode = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge ACLK); #1;
      end
      w = $urandom;
      l = (n == 999) || ($urandom_range(0, 5) == 0);
      send(w, l);
      m[mi*32 +: 32] = w;
      if (mi == 7 || l) begin
        e.d = m;
        e.l = l;
        e.k = (mi == 7) ? 32'hFFFFFFFF : ((32'h1 << (4 * (mi + 1))) - 32'h1);
        expq.push_back(e);
        m  = '0;
        mi = 0;
      end else begin
        mi++;
      end
    end
    while (cap.size() < expq.size() && t < 3000) begin
      @(negedge ACLK);
      t++;
    end
    repeat (3) @(negedge ACLK);
    rand_mode = 1'b0;
    vectors++;
    if (cap.size() != expq.size()) begin
      fails++; $display("FAIL rand_count: beats=%0d required %0d", cap.size(), expq.size());
    end
    for (int b = 0; b < expq.size() && b < cap.size(); b++) begin
      vectors++;
      if (cap[b].d !== expq[b].d || cap[b].l !== expq[b].l
`ifdef LIST_PACKER_TKEEP_EN
          || cap[b].k !== expq[b].k
`endif
         ) begin
        fails++;
        $display("FAIL rand_beat%0d: tdata=%h tlast=%b tkeep=%h required %h %b %h",
                 b, cap[b].d, cap[b].l, cap[b].k, expq[b].d, expq[b].l, expq[b].k);
      end
    end
    @(posedge ACLK); #1;
  endtask

  task automatic test_reset_mid;
    cap.delete();
    tready_val = 1'b1;
    for (int i = 0; i < 5; i++) send(32'h300 + 32'(i), 1'b0);
    ARESETn = 1'b0;
    #2;
    vectors++;
    if (TVALID !== 1'b0 || O_READY !== 1'b0) begin
      fails++; $display("FAIL midreset: tvalid=%b o_ready=%b required 0 0", TVALID, O_READY);
    end
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    for (int i = 0; i < 8; i++) send(32'h400 + 32'(i), 1'b0);
    wait_beats(1, 50);
    vectors++;
    if (cap.size() != 1) begin
      fails++; $display("FAIL midreset_count: beats=%0d required 1", cap.size());
    end
    if (cap.size() > 0) begin
      vectors++;
      if (cap[0].d !== 256'h00000407_00000406_00000405_00000404_00000403_00000402_00000401_00000400
          || cap[0].l !== 1'b0) begin
        fails++; $display("FAIL midreset_beat: tdata=%h tlast=%b required fresh 400..407 tlast 0", cap[0].d, cap[0].l);
      end
`ifdef LIST_PACKER_TKEEP_EN
      vectors++;
      if (cap[0].k !== 32'hFFFFFFFF) begin
        fails++; $display("FAIL midreset_tkeep: tkeep=%h required ffffffff", cap[0].k);
      end
`endif
    end
    @(posedge ACLK); #1;
  endtask

  task automatic test_single;
    cap.delete();
    send(32'hDEADBEEF, 1'b1);
    wait_beats(1, 50);
    vectors++;
    if (cap.size() != 1) begin
      fails++; $display("FAIL single_count: beats=%0d required 1", cap.size());
    end
    if (cap.size() > 0) begin
      vectors++;
      if (cap[0].d !== 256'h00000000_00000000_00000000_00000000_00000000_00000000_00000000_DEADBEEF
          || cap[0].l !== 1'b1) begin
        fails++; $display("FAIL single_beat: tdata=%h tlast=%b required deadbeef in lane0 tlast 1", cap[0].d, cap[0].l);
      end
`ifdef LIST_PACKER_TKEEP_EN
      vectors++;
      if (cap[0].k !== 32'h0000000F) begin
        fails++; $display("FAIL single_tkeep: tkeep=%h required 0000000f", cap[0].k);
      end
`endif
    end
    @(posedge ACLK); #1;
  endtask

  initial begin
    ARESETn    = 1'b0;
    IN         = '0;
    I_VALID    = 1'b0;
    I_LAST     = 1'b0;
    tready_val = 1'b0;
    rand_mode  = 1'b0;
    test_reset;
    test_full_beat;
    test_partial;
    test_backpressure;
    test_random;
    test_reset_mid;
    test_single;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
